utopia_phy_rx_source: RTL and testbench

- PHY-side source for the Utopia receive direction. It drives data, soc and clav into a core-side receive port (CoreReceive) and obeys that port's active-low en.
- The host loads whole 53-byte ATM cells in parallel into a small cell buffer. The block streams each buffered cell out one byte at a time.
- Used as the PHY model in the testbench environment and as the synthesizable PHY end of a loopback path.

---
 rtl/utopia_phy_rx_source.sv | 155 +++++++++++++++
 tb/tb_utopia_phy_rx_source.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/utopia_phy_rx_source.sv
// PHY-side Utopia receive source: buffers whole ATM cells loaded in parallel and
// streams them byte-by-byte into a core receiver under its active-low read enable.
//
// state | meaning
// IDLE  | no cell in flight; soc low, data holds last byte sent
// SEND  | cell in flight; ptr is next byte, done marks byte 52 already presented
module utopia_phy_rx_source #(
   parameter int IfWidth   = 8,
   parameter int NumCells  = 2,
   parameter int CellBytes = 53
) (
   input  logic                           clk_in,
   input  logic                           reset,
   input  logic [CellBytes*IfWidth-1:0]   cell_in,
   input  logic                           cell_valid,
   output logic                           cell_ready,
   input  logic                           en,
   output logic [IfWidth-1:0]             data,
   output logic                           soc,
   output logic                           clav,
   output logic                           busy,
   output logic [15:0]                    cells_sent
);

   localparam int CellW = CellBytes * IfWidth;
   localparam int IdxW  = (NumCells > 1) ? $clog2(NumCells) : 1;
   localparam int CntW  = $clog2(NumCells + 1);
   localparam logic [5:0] LastPtr = 6'(CellBytes - 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

   logic [CellW-1:0]   mem [NumCells];
   logic [IdxW-1:0]    wr_idx, rd_idx, rd_idx_n;
   logic [CntW-1:0]    stored_q, stored_n;
   logic [0:0]         state_q, state_n;
   logic [5:0]         ptr_q, ptr_n;
   logic               done_q, done_n;
   logic [IfWidth-1:0] data_q, data_n;
   logic               soc_q, soc_n;
   logic               clav_q, clav_n;
   logic [15:0]        sent_q, sent_n;
   logic               wr, free, in_flight_n;
   logic [CellW-1:0]   cur_cell;

   function automatic logic [IfWidth-1:0] pick(input logic [CellW-1:0] c, input logic [5:0] idx);
      logic [CellW-1:0] s;
      s = c << (IfWidth * int'(idx));
      return s[CellW-1 -: IfWidth];
   endfunction

   function automatic logic [IdxW-1:0] bump(input logic [IdxW-1:0] i);
      if (i == IdxW'(NumCells - 1)) return '0;
      return i + 1'b1;
   endfunction

   assign cell_ready = (stored_q < CntW'(NumCells));
   assign wr         = cell_valid && cell_ready;
   assign cur_cell   = mem[rd_idx];

   always_ff @(posedge clk_in) begin
      if (wr) mem[wr_idx] <= cell_in;
   end

   always_comb begin
      state_n  = state_q;
      ptr_n    = ptr_q;
      done_n   = done_q;
      data_n   = data_q;
      soc_n    = soc_q;
      sent_n   = sent_q;
      rd_idx_n = rd_idx;
      free     = 1'b0;
      case (state_q)
         IDLE: begin
            soc_n = 1'b0;
            if (!en && clav_q) begin
               data_n  = pick(cur_cell, 6'd0);
               soc_n   = 1'b1;
               ptr_n   = 6'd1;
               done_n  = 1'b0;
               state_n = SEND;
            end
         end
         default: begin
            if (!en) begin
               if (done_q) begin
                  // back-to-back: next cell starts with no idle gap
                  if (clav_q) begin
                     data_n = pick(cur_cell, 6'd0);
                     soc_n  = 1'b1;
                     ptr_n  = 6'd1;
                     done_n = 1'b0;
                  end else begin
                     soc_n   = 1'b0;
                     done_n  = 1'b0;
                     ptr_n   = 6'd0;
                     state_n = IDLE;
                  end
               end else begin
                  data_n = pick(cur_cell, ptr_q);
                  soc_n  = 1'b0;
                  if (ptr_q == LastPtr) begin
                     done_n   = 1'b1;
                     ptr_n    = 6'd0;
                     free     = 1'b1;
                     sent_n   = sent_q + 16'd1;
                     rd_idx_n = bump(rd_idx);
                  end else begin
                     ptr_n = ptr_q + 6'd1;
                  end
               end
            end
         end
      endcase
   end

   // The in-flight cell stops hiding a slot from clav once its last byte is out.
   assign stored_n    = stored_q + CntW'(wr) - CntW'(free);
   assign in_flight_n = (state_n == SEND) && !done_n;
   assign clav_n      = (stored_n > CntW'(in_flight_n));

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         done_q   <= 1'b0;
         data_q   <= '0;
         soc_q    <= 1'b0;
         clav_q   <= 1'b0;
         sent_q   <= '0;
         stored_q <= '0;
         wr_idx   <= '0;
         rd_idx   <= '0;
      end else begin
         state_q  <= state_n;
         ptr_q    <= ptr_n;
         done_q   <= done_n;
         data_q   <= data_n;
         soc_q    <= soc_n;
         clav_q   <= clav_n;
         sent_q   <= sent_n;
         stored_q <= stored_n;
         rd_idx   <= rd_idx_n;
         if (wr) wr_idx <= bump(wr_idx);
      end
   end

   assign data       = data_q;
   assign soc        = soc_q;
   assign clav       = clav_q;
   assign busy       = (state_q == SEND);
   assign cells_sent = sent_q;

endmodule

// File: tb/tb_utopia_phy_rx_source.sv
// Self-checking bench for utopia_phy_rx_source: queue-based cell model checked every
// cycle, plus directed literal expectations along the scenario.
module tb_utopia_phy_rx_source;
   localparam int NC = 2;

   logic         clk_in = 1'b0;
   logic         reset = 1'b0;
   logic [423:0] cell_in = '0;
   logic         cell_valid = 1'b0;
   logic         en = 1'b1;
   logic         cell_ready;
   logic [7:0]   data;
   logic         soc, clav, busy;
   logic [15:0]  cells_sent;

   int checks = 0;
   int errors = 0;
   bit cmp_on = 1'b0;

   always #5 clk_in = ~clk_in;

   utopia_phy_rx_source #(.IfWidth(8), .NumCells(NC), .CellBytes(53)) dut (
      .clk_in(clk_in), .reset(reset), .cell_in(cell_in), .cell_valid(cell_valid),
      .cell_ready(cell_ready), .en(en), .data(data), .soc(soc), .clav(clav),
      .busy(busy), .cells_sent(cells_sent)
   );

   // model: cells held (head is the one in flight or next to go) and stream position
   logic [423:0] pend [$];
   bit           m_busy, m_done, m_soc, m_clav;
   logic [7:0]   m_data;
   logic [15:0]  m_sent;
   int           nxt;

   function automatic logic [7:0] byte_of(input logic [423:0] c, input int i);
      return c[8*(52-i) +: 8];
   endfunction

   function automatic logic [423:0] make_cell(input logic [7:0] base);
      logic [423:0] c;
      c = '0;
      for (int i = 0; i < 53; i++) c[8*(52-i) +: 8] = base + 8'(i);
      return c;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      pend.delete();
      m_busy = 0; m_done = 0; m_soc = 0; m_clav = 0;
      m_data = '0; m_sent = '0; nxt = 0;
   endtask

   task automatic model_start();
      m_data = byte_of(pend[0], 0);
      m_soc  = 1; nxt = 1; m_busy = 1; m_done = 0;
   endtask

   task automatic model_step();
      bit wr;
      wr = cell_valid && (pend.size() < NC);
      if (!en) begin
         if (!m_busy || m_done) begin
            if (m_clav) model_start();
            else begin m_busy = 0; m_done = 0; m_soc = 0; end
         end else begin
            m_data = byte_of(pend[0], nxt);
            m_soc  = 0;
            if (nxt == 52) begin
               m_done = 1;
               pend.delete(0);
               m_sent++;
            end else nxt++;
         end
      end else if (!m_busy) m_soc = 0;
      if (wr) pend.push_back(cell_in);
      m_clav = pend.size() > ((m_busy && !m_done) ? 1 : 0);
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk_in or negedge reset);
         if (!reset) model_reset();
         else model_step();
      end
   end

   initial forever begin
      @(negedge clk_in);
      if (cmp_on) begin
         chk("m_data", data, m_data);
         chk("m_soc", soc, m_soc);
         chk("m_clav", clav, m_clav);
         chk("m_busy", busy, m_busy);
         chk("m_cells_sent", cells_sent, m_sent);
         chk("m_cell_ready", cell_ready, pend.size() < NC);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic load(input logic [423:0] c);
      cell_in = c; cell_valid = 1'b1;
      @(negedge clk_in);
      cell_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int k = 0; k < 200; k++) begin
         if (!busy) break;
         @(negedge clk_in);
      end
      chk(name, busy, 1'b0);
   endtask

   initial begin
      repeat (3) @(negedge clk_in);
      reset = 1'b1; cmp_on = 1'b1;
      chk("rst_ready", cell_ready, 1'b1);
      chk("rst_clav", clav, 1'b0);
      chk("rst_data", data, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_sent", cells_sent, 16'h0);

      // single cell, en held low
      load(make_cell(8'h00));
      chk("one_clav", clav, 1'b1);
      en = 1'b0;
      @(negedge clk_in);
      chk("one_soc", soc, 1'b1);
      chk("one_b0", data, 8'h00);
      chk("one_clav_drop", clav, 1'b0);
      for (int i = 1; i <= 52; i++) begin
         @(negedge clk_in);
         chk("one_byte", data, 32'(i));
      end
      chk("one_sent", cells_sent, 16'd1);
      @(negedge clk_in);
      chk("one_idle", busy, 1'b0);
      chk("one_hold", data, 8'h34);
      en = 1'b1;

      // fill buffer, third cell rejected, back-to-back stream
      cell_in = make_cell(8'h40); cell_valid = 1'b1;
      @(negedge clk_in);
      cell_in = make_cell(8'h80);
      @(negedge clk_in);
      chk("full_ready", cell_ready, 1'b0);
      cell_in = make_cell(8'hC0);
      @(negedge clk_in);
      chk("full_ready2", cell_ready, 1'b0);
      cell_valid = 1'b0; en = 1'b0;
      for (int k = 0; k < 106; k++) begin
         @(negedge clk_in);
         chk("b2b_data", data, (k < 53) ? 32'(8'h40 + 8'(k)) : 32'(8'h80 + 8'(k - 53)));
         chk("b2b_soc", soc, (k == 0 || k == 53));
      end
      chk("b2b_sent", cells_sent, 16'd3);
      @(negedge clk_in);
      chk("b2b_idle", busy, 1'b0);
      chk("b2b_noclav", clav, 1'b0);
      en = 1'b1;

      // mid-cell pause
      load(make_cell(8'h00));
      en = 1'b0;
      @(negedge clk_in);
      chk("pause_soc", soc, 1'b1);
      for (int i = 1; i <= 10; i++) @(negedge clk_in);
      chk("pause_b10", data, 8'h0A);
      en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_in);
         chk("pause_hold", data, 8'h0A);
         chk("pause_soc0", soc, 1'b0);
      end
      en = 1'b0;
      @(negedge clk_in);
      chk("pause_b11", data, 8'h0B);
      wait_idle("pause_done");
      chk("pause_sent", cells_sent, 16'd4);
      en = 1'b1;

      // reset mid-cell
      load(make_cell(8'h60));
      en = 1'b0;
      for (int i = 0; i <= 20; i++) @(negedge clk_in);
      chk("mr_b20", data, 8'h74);
      #1 reset = 1'b0;
      #1;
      chk("mr_clav", clav, 1'b0);
      chk("mr_soc", soc, 1'b0);
      chk("mr_data", data, 8'h00);
      chk("mr_busy", busy, 1'b0);
      chk("mr_sent", cells_sent, 16'd0);
      chk("mr_ready", cell_ready, 1'b1);
      @(negedge clk_in);
      reset = 1'b1; en = 1'b1;
      load(make_cell(8'hA0));
      en = 1'b0;
      @(negedge clk_in);
      chk("mr_fresh_soc", soc, 1'b1);
      chk("mr_fresh_b0", data, 8'hA0);
      wait_idle("mr_done");

      // en low with empty buffer
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_in);
         chk("empty_soc", soc, 1'b0);
         chk("empty_data", data, 8'hD4);
         chk("empty_busy", busy, 1'b0);
      end
      en = 1'b1;

      // counter wrap from a preset value
      force dut.sent_q = 16'hFFFF;
      m_sent = 16'hFFFF;
      #1 release dut.sent_q;
      #1 chk("wrap_preset", cells_sent, 16'hFFFF);
      @(negedge clk_in);
      load(make_cell(8'h10));
      en = 1'b0;
      @(negedge clk_in);
      wait_idle("wrap_done");
      chk("wrap_sent", cells_sent, 16'h0000);
      en = 1'b1;
      @(negedge clk_in);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
